vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Slot-based arbiter sharing one synchronous single-port VRAM between display fetch and CPU.
// Reads return two clk edges after issue through a small owner pipeline.
module vram_arbiter #(
  parameter int DISPLAY_SLOTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_en,
  input  logic        disp_req,
  input  logic [15:0] disp_addr,
  output logic        disp_ack,
  output logic [7:0]  disp_rdata,
  output logic        disp_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [2:0] DISP_SLOTS = 3'(DISPLAY_SLOTS);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CPU  = 2'd2
  } grant_e;

  grant_e      grant_s;
  logic        disp_pri_s;
  logic        capture_s;
  logic        addr_msb_unused;

  logic [1:0]  slot_q, slot_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_we_q, buf_we_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_wdata_q, buf_wdata_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        disp_ack_q, disp_ack_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        p1_valid_q, p1_valid_d;
  logic        p1_cpu_q, p1_cpu_d;
  logic        p2_valid_q, p2_valid_d;
  logic        p2_cpu_q, p2_cpu_d;
  logic        disp_rvalid_q, disp_rvalid_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic [7:0]  disp_rdata_q, disp_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  // VRAM is 32K; the top address bit of both requesters is discarded
  assign addr_msb_unused = disp_addr[15] ^ cpu_addr[15];

  // Slot counter and grant selection
  always_comb begin
    slot_d     = slot_q;
    grant_s    = GNT_NONE;
    disp_pri_s = ({1'b0, slot_q} < DISP_SLOTS);
    if (slot_en) begin
      slot_d = slot_q + 2'd1;
      if (disp_pri_s) begin
        if (disp_req) begin
          grant_s = GNT_DISP;
        end else if (buf_valid_q) begin
          grant_s = GNT_CPU;
        end else begin
          grant_s = GNT_NONE;
        end
      end else begin
        if (buf_valid_q) begin
          grant_s = GNT_CPU;
        end else if (disp_req) begin
          grant_s = GNT_DISP;
        end else begin
          grant_s = GNT_NONE;
        end
      end
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // CPU one-entry buffer and busy flag
  always_comb begin
    capture_s   = cpu_req && !cpu_busy_q;
    buf_valid_d = buf_valid_q;
    buf_we_d    = buf_we_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    cpu_busy_d  = cpu_busy_q;
    // buf_valid_q implies cpu_busy_q, so capture and CPU issue never coincide
    if (capture_s) begin
      buf_valid_d = 1'b1;
      buf_we_d    = cpu_we;
      buf_addr_d  = cpu_addr[14:0];
      buf_wdata_d = cpu_wdata;
      cpu_busy_d  = 1'b1;
    end else if (grant_s == GNT_CPU) begin
      buf_valid_d = 1'b0;
      if (buf_we_q) begin
        cpu_busy_d = 1'b0;
      end else begin
        cpu_busy_d = 1'b1;
      end
    end else if (p2_valid_q && p2_cpu_q) begin
      cpu_busy_d = 1'b0;
    end else begin
      cpu_busy_d = cpu_busy_q;
    end
  end

  // Memory port, ack and read-return owner pipeline
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    disp_ack_d  = 1'b0;
    p1_valid_d  = 1'b0;
    p1_cpu_d    = 1'b0;
    case (grant_s)
      GNT_DISP: begin
        mem_addr_d = disp_addr[14:0];
        disp_ack_d = 1'b1;
        p1_valid_d = 1'b1;
        p1_cpu_d   = 1'b0;
      end
      GNT_CPU: begin
        mem_addr_d  = buf_addr_q;
        mem_we_d    = buf_we_q;
        mem_wdata_d = buf_wdata_q;
        p1_valid_d  = !buf_we_q;
        p1_cpu_d    = 1'b1;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
    p2_valid_d    = p1_valid_q;
    p2_cpu_d      = p1_cpu_q;
    disp_rvalid_d = p2_valid_q && !p2_cpu_q;
    cpu_rvalid_d  = p2_valid_q && p2_cpu_q;
    if (disp_rvalid_d) begin
      disp_rdata_d = mem_rdata;
    end else begin
      disp_rdata_d = disp_rdata_q;
    end
    if (cpu_rvalid_d) begin
      cpu_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q        <= 2'd0;
      buf_valid_q   <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= 15'd0;
      buf_wdata_q   <= 8'd0;
      cpu_busy_q    <= 1'b0;
      disp_ack_q    <= 1'b0;
      mem_addr_q    <= 15'd0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
      p1_valid_q    <= 1'b0;
      p1_cpu_q      <= 1'b0;
      p2_valid_q    <= 1'b0;
      p2_cpu_q      <= 1'b0;
      disp_rvalid_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      disp_rdata_q  <= 8'd0;
      cpu_rdata_q   <= 8'd0;
    end else begin
      slot_q        <= slot_d;
      buf_valid_q   <= buf_valid_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      cpu_busy_q    <= cpu_busy_d;
      disp_ack_q    <= disp_ack_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      p1_valid_q    <= p1_valid_d;
      p1_cpu_q      <= p1_cpu_d;
      p2_valid_q    <= p2_valid_d;
      p2_cpu_q      <= p2_cpu_d;
      disp_rvalid_q <= disp_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

  assign disp_ack    = disp_ack_q;
  assign disp_rdata  = disp_rdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign cpu_busy    = cpu_busy_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: instance A (DISPLAY_SLOTS=2) and instance B (DISPLAY_SLOTS=4),
// each with its own synchronous RAM model; negedge monitors pop expected responses.
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic slot_en = 1'b0;
  logic ram_load = 1'b1;

  logic        a_disp_req, a_disp_ack, a_disp_rvalid, a_cpu_req, a_cpu_we, a_cpu_busy, a_cpu_rvalid, a_mem_we;
  logic [15:0] a_disp_addr, a_cpu_addr;
  logic [7:0]  a_disp_rdata, a_cpu_wdata, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic [14:0] a_mem_addr;
  logic        b_disp_req, b_disp_ack, b_disp_rvalid, b_cpu_req, b_cpu_we, b_cpu_busy, b_cpu_rvalid, b_mem_we;
  logic [15:0] b_disp_addr, b_cpu_addr;
  logic [7:0]  b_disp_rdata, b_cpu_wdata, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic [14:0] b_mem_addr;

  logic [7:0] ram_a [0:32767];
  logic [7:0] ram_b [0:32767];

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        chk_slot;
  } wr_t;

  wr_t        wr_a_q[$];
  wr_t        wr_b_q[$];
  logic [7:0] disp_a_q[$];
  logic [7:0] cpu_a_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   a_wr_cnt = 0;
  int   b_wr_cnt = 0;
  int   b_wr_cyc = 0;
  int   cyc = 0;
  logic a_stream = 1'b0;
  logic b_stream = 1'b0;
  logic [1:0] tb_slot;
  logic dreq_b_prev = 1'b0;

  vram_arbiter #(.DISPLAY_SLOTS(2)) u_dut_a (
    .clk(clk), .reset(reset), .slot_en(slot_en),
    .disp_req(a_disp_req), .disp_addr(a_disp_addr), .disp_ack(a_disp_ack),
    .disp_rdata(a_disp_rdata), .disp_rvalid(a_disp_rvalid),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_busy(a_cpu_busy), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  vram_arbiter #(.DISPLAY_SLOTS(4)) u_dut_b (
    .clk(clk), .reset(reset), .slot_en(slot_en),
    .disp_req(b_disp_req), .disp_addr(b_disp_addr), .disp_ack(b_disp_ack),
    .disp_rdata(b_disp_rdata), .disp_rvalid(b_disp_rvalid),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_busy(b_cpu_busy), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      32'h0000: init_val = 8'h11;
      32'h0001: init_val = 8'h22;
      32'h0010: init_val = 8'h3C;
      32'h0100: init_val = 8'h5A;
      32'h0300: init_val = 8'hEE;
      default:  init_val = 8'(i) ^ 8'h96;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected output pulse (t=%0t)", nm, $time);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Synchronous RAM models with one-cycle read latency
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 32768; i++) begin
        ram_a[i] <= init_val(i);
        ram_b[i] <= init_val(i);
      end
    end else begin
      if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    end
    a_mem_rdata <= ram_a[a_mem_addr];
    b_mem_rdata <= ram_b[b_mem_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_slot <= 2'd0;
    else if (slot_en) tb_slot <= tb_slot + 2'd1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dreq_b_prev <= b_disp_req;
  end

  // Monitors: pop the scoreboard whenever a DUT presents a write or a read return
  always @(negedge clk) begin
    if (reset) begin
      if (a_mem_we) begin
        if (wr_a_q.size() == 0) unexpected("a_write");
        else begin
          wr_t e;
          logic [1:0] islot;
          e = wr_a_q.pop_front();
          islot = tb_slot - 2'd1;
          check("a_wr_addr", 32'(a_mem_addr), 32'(e.addr));
          check("a_wr_data", 32'(a_mem_wdata), 32'(e.data));
          if (e.chk_slot) check("a_wr_cpu_slot", 32'(islot >= 2'd2), 32'd1);
          a_wr_cnt++;
        end
      end
      if (a_disp_rvalid) begin
        if (disp_a_q.size() != 0) check("a_disp_rdata", 32'(a_disp_rdata), 32'(disp_a_q.pop_front()));
        else if (a_stream) check("a_disp_stream", 32'(a_disp_rdata), 32'h5A);
        else unexpected("a_disp_rvalid");
      end
      if (a_cpu_rvalid) begin
        if (cpu_a_q.size() == 0) unexpected("a_cpu_rvalid");
        else begin
          check("a_cpu_rdata", 32'(a_cpu_rdata), 32'(cpu_a_q.pop_front()));
          check("a_busy_at_rvalid", 32'(a_cpu_busy), 32'd0);
        end
      end
      if (b_mem_we) begin
        if (wr_b_q.size() == 0) unexpected("b_write");
        else begin
          wr_t e;
          e = wr_b_q.pop_front();
          check("b_wr_addr", 32'(b_mem_addr), 32'(e.addr));
          check("b_wr_data", 32'(b_mem_wdata), 32'(e.data));
          check("b_wr_disp_idle", 32'(dreq_b_prev), 32'd0);
          b_wr_cyc = cyc;
          b_wr_cnt++;
        end
      end
      if (b_disp_rvalid) begin
        if (b_stream) check("b_disp_stream", 32'(b_disp_rdata), 32'h5A);
        else unexpected("b_disp_rvalid");
      end
      if (b_cpu_rvalid) unexpected("b_cpu_rvalid");
    end
  end

  initial begin
    int t;
    int drop_cyc;
    a_disp_req = 1'b0; a_disp_addr = 16'h0; a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 16'h0; a_cpu_wdata = 8'h0;
    b_disp_req = 1'b0; b_disp_addr = 16'h0; b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 16'h0; b_cpu_wdata = 8'h0;
    repeat (2) tick;
    ram_load = 1'b0;

    check("rst_a_busy", 32'(a_cpu_busy), 32'd0);
    check("rst_a_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_a_mem_addr", 32'(a_mem_addr), 32'd0);
    check("rst_a_mem_wdata", 32'(a_mem_wdata), 32'd0);
    check("rst_a_disp_ack", 32'(a_disp_ack), 32'd0);
    check("rst_a_rvalids", 32'({a_disp_rvalid, a_cpu_rvalid}), 32'd0);
    check("rst_a_rdatas", 32'({a_disp_rdata, a_cpu_rdata}), 32'd0);
    check("rst_b_busy", 32'(b_cpu_busy), 32'd0);

    // Continuous display, CPU write must land in a CPU-priority slot
    reset = 1'b1;
    slot_en = 1'b1;
    a_disp_req = 1'b1; a_disp_addr = 16'h0100; a_stream = 1'b1;
    tick;
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 16'h0200; a_cpu_wdata = 8'hA5;
    wr_a_q.push_back('{addr: 15'h0200, data: 8'hA5, chk_slot: 1'b1});
    tick;
    a_cpu_req = 1'b0;
    t = 0;
    while (a_wr_cnt < 1 && t < 16) begin tick; t++; end
    check("a_wr_issued", 32'(a_wr_cnt), 32'd1);
    tick;
    check("a_we_single", 32'(a_mem_we), 32'd0);
    a_disp_req = 1'b0;
    repeat (4) tick;
    a_stream = 1'b0;

    // Read back the written byte
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 16'h0200;
    cpu_a_q.push_back(8'hA5);
    tick;
    a_cpu_req = 1'b0;
    t = 0;
    while (a_cpu_busy && t < 10) begin tick; t++; end
    check("a_rd1_done", 32'(a_cpu_busy), 32'd0);
    tick;

    // Read with bit 15 set, stalled by slot_en=0; a second request while busy is ignored
    slot_en = 1'b0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 16'h8010;
    cpu_a_q.push_back(8'h3C);
    tick;
    a_cpu_we = 1'b1; a_cpu_addr = 16'h0300; a_cpu_wdata = 8'h77;
    repeat (3) tick;
    check("a_busy_stalled", 32'(a_cpu_busy), 32'd1);
    check("a_no_early_rvalid", 32'(cpu_a_q.size()), 32'd1);
    slot_en = 1'b1;
    tick;
    a_cpu_req = 1'b0;
    check("a_rd_mem_addr", 32'(a_mem_addr), 32'h0010);
    t = 0;
    while (a_cpu_busy && t < 10) begin tick; t++; end
    check("a_rd2_done", 32'(a_cpu_busy), 32'd0);
    repeat (4) tick;

    // Alternating display reads every edge
    for (int k = 0; k < 8; k++) begin
      a_disp_req = 1'b1;
      a_disp_addr = (k % 2 == 1) ? 16'h0001 : 16'h0000;
      disp_a_q.push_back((k % 2 == 1) ? 8'h22 : 8'h11);
      if (k > 0) check("a_disp_ack", 32'(a_disp_ack), 32'd1);
      tick;
    end
    a_disp_req = 1'b0;
    check("a_disp_ack_last", 32'(a_disp_ack), 32'd1);
    repeat (4) tick;
    check("a_disp_all_seen", 32'(disp_a_q.size()), 32'd0);
    check("a_cpu_rdata_held", 32'(a_cpu_rdata), 32'h3C);

    // Reset one cycle after a CPU read issue drops the read
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 16'h0010;
    tick;
    a_cpu_req = 1'b0;
    tick;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(a_cpu_busy), 32'd0);
    check("arst_mem_we", 32'(a_mem_we), 32'd0);
    check("arst_cpu_rvalid", 32'(a_cpu_rvalid), 32'd0);
    check("arst_cpu_rdata", 32'(a_cpu_rdata), 32'd0);
    check("arst_mem_addr", 32'(a_mem_addr), 32'd0);
    repeat (2) tick;
    reset = 1'b1;
    repeat (5) tick;

    // DISPLAY_SLOTS=4: CPU write blocked while display requests
    b_disp_req = 1'b1; b_disp_addr = 16'h0100; b_stream = 1'b1;
    tick;
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 16'h0400; b_cpu_wdata = 8'h3E;
    wr_b_q.push_back('{addr: 15'h0400, data: 8'h3E, chk_slot: 1'b0});
    tick;
    b_cpu_req = 1'b0;
    repeat (10) tick;
    check("b_wr_blocked", 32'(b_wr_cnt), 32'd0);
    check("b_busy_pending", 32'(b_cpu_busy), 32'd1);
    b_disp_req = 1'b0;
    drop_cyc = cyc;
    t = 0;
    while (b_wr_cnt < 1 && t < 8) begin tick; t++; end
    check("b_wr_issued", 32'(b_wr_cnt), 32'd1);
    check("b_wr_next_edge", 32'(b_wr_cyc), 32'(drop_cyc + 1));
    check("b_busy_cleared", 32'(b_cpu_busy), 32'd0);
    repeat (4) tick;
    b_stream = 1'b0;

    check("sb_wr_a_empty", 32'(wr_a_q.size()), 32'd0);
    check("sb_cpu_a_empty", 32'(cpu_a_q.size()), 32'd0);
    check("sb_wr_b_empty", 32'(wr_b_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
